sample_packer: RTL and testbench

SAMPLE_PACKER -- requirements
Module: sample_packer

---
 rtl/sample_packer_pkg.sv | 14 +
 rtl/sample_packer_bitplane_transpose.sv | 22 ++
 rtl/sample_packer.sv | 122 ++++++++++++
 tb/tb_sample_packer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sample_packer_pkg.sv
// rtl/sample_packer_pkg.sv - shared FSM encoding and bus-width helper for sample_packer
package sample_packer_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic int bus_width(input int w, input int k);
      return w * k;
   endfunction

endpackage

// File: rtl/sample_packer_bitplane_transpose.sv
// rtl/sample_packer_bitplane_transpose.sv - combinational k-by-W slot array to bit-plane bus
module bitplane_transpose
   import sample_packer_pkg::*;
#(
   parameter int m = 3,
   parameter int n = 2,
   parameter int k = 4
) (
   input  logic [bus_width(m+n, k)-1:0] slots,
   output logic [bus_width(m+n, k)-1:0] planes
);

   localparam int W = m + n;

   // slot j occupies slots[j*W +: W]; bit b of slot j lands at planes[b*k + j]
   for (genvar b = 0; b < W; b++) begin : g_bit
      for (genvar j = 0; j < k; j++) begin : g_slot
         assign planes[b*k + j] = slots[j*W + b];
      end
   end

endmodule

// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - packs k samples into a bit-plane batch for an accumulator (option: PACKER_HOLDOFF_EN)
module sample_packer
   import sample_packer_pkg::*;
#(
   parameter int m = 3,
   parameter int n = 2,
   parameter int k = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [m+n-1:0]            in_data,
   input  logic                      flush,
   input  logic                      acc_ready,
   output logic                      pl,
   output logic [bus_width(m+n, k)-1:0] din,
   output logic                      busy
);

   localparam int W  = m + n;
   localparam int BW = bus_width(W, k);
   localparam int CW = $clog2(k) + 1;

   state_t          state, next_state;
   logic [CW-1:0]   count, cnt_acc;
   logic [BW-1:0]   slots, next_slots, din_next;
   logic            accept, go_load;

`ifdef PACKER_HOLDOFF_EN
   localparam int HW = $clog2(k + 2) + 1;
   logic [HW-1:0]   hold_cnt;
`else
   logic            seen_low;
`endif

   assign in_ready = (state == FILL);
   assign busy     = (state != FILL);
   assign accept   = in_valid && in_ready;
   assign cnt_acc  = count + CW'(accept);
   assign go_load  = in_ready && ((accept && count == CW'(k - 1)) ||
                                  (flush && cnt_acc != '0));

   // the new sample goes in first, then any flush pads everything after it
   always_comb begin
      next_slots = slots;
      for (int j = 0; j < k; j++) begin
         if (accept && count == CW'(j))
            next_slots[j*W +: W] = in_data;
         else if (flush && cnt_acc <= CW'(j))
            next_slots[j*W +: W] = '0;
      end
   end

   bitplane_transpose #(.m(m), .n(n), .k(k)) u_transpose (
      .slots  (next_slots),
      .planes (din_next)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= FILL;
         count <= '0;
         slots <= '0;
         din   <= '0;
      end else begin
         state <= next_state;
         if (accept || go_load)
            slots <= next_slots;
         if (go_load) begin
            count <= '0;
            din   <= din_next;
         end else if (accept) begin
            count <= cnt_acc;
         end
      end
   end

`ifdef PACKER_HOLDOFF_EN
   // loaded to k+1 so HOLD spans k+2 cycles counting down to zero
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         hold_cnt <= '0;
      else if (state == LOAD)
         hold_cnt <= HW'(k + 1);
      else if (state == HOLD && hold_cnt != '0)
         hold_cnt <= hold_cnt - 1'b1;
   end
`else
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         seen_low <= 1'b0;
      else if (state != HOLD)
         seen_low <= 1'b0;
      else if (!acc_ready)
         seen_low <= 1'b1;
   end
`endif

   always_comb begin
      next_state = state;
      pl         = 1'b0;
      case (state)
         FILL: if (go_load) next_state = LOAD;
         LOAD: begin
            if (acc_ready) begin
               pl         = 1'b1;
               next_state = HOLD;
            end
         end
         HOLD: begin
`ifdef PACKER_HOLDOFF_EN
            if (hold_cnt == '0) next_state = FILL;
`else
            if (seen_low && acc_ready) next_state = FILL;
`endif
         end
         default: next_state = FILL;
      endcase
   end

endmodule

// File: tb/tb_sample_packer.sv
// tb/tb_sample_packer.sv - directed table-driven bench for sample_packer (m=3, n=2, k=4)
module tb_sample_packer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_data;
   logic        flush;
   logic        acc_ready;
   logic        pl;
   logic [19:0] din;
   logic        busy;

   int tests  = 0;
   int failed = 0;
   int pl_cnt = 0;
   int pl_base;

   typedef struct {
      string       name;
      int          nsamp;
      logic        flush_last;
      logic [19:0] samples;
      logic [19:0] exp_din;
   } vec_t;

   vec_t vecs[6];

   sample_packer #(.m(3), .n(2), .k(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .acc_ready (acc_ready),
      .pl        (pl),
      .din       (din),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (pl) pl_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [4:0] d, input logic f);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      flush    = f;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   // called at the first HOLD negedge; returns at a negedge back in FILL
   task automatic release_hold(input string name);
`ifdef PACKER_HOLDOFF_EN
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check({name, " holdoff busy"}, busy, 1);
      end
      @(negedge clk);
      check({name, " holdoff in_ready"}, in_ready, 1);
`else
      check({name, " hold with acc_ready high"}, in_ready, 0);
      acc_ready = 1'b0;
      @(negedge clk);
      check({name, " hold after low"}, in_ready, 0);
      acc_ready = 1'b1;
      @(negedge clk);
      check({name, " in_ready after toggle"}, in_ready, 1);
`endif
   endtask

   initial begin
      vecs[0] = '{"seq1234",   4, 1'b0, {5'd4,  5'd3,  5'd2,  5'd1 }, 20'h00865};
      vecs[1] = '{"flush1F1F", 2, 1'b1, {5'd0,  5'd0,  5'h1F, 5'h1F}, 20'h33333};
      vecs[2] = '{"seq8000",   4, 1'b0, {5'd0,  5'd0,  5'd0,  5'd8 }, 20'h01000};
      vecs[3] = '{"flush1",    1, 1'b1, {5'd0,  5'd0,  5'd0,  5'h1F}, 20'h11111};
      vecs[4] = '{"flush3",    3, 1'b1, {5'd0,  5'd4,  5'd2,  5'd1 }, 20'h00421};
      vecs[5] = '{"alt1F",     4, 1'b0, {5'd0,  5'h1F, 5'd0,  5'h1F}, 20'h55555};

      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      acc_ready = 1'b1;
      #12;
      check("reset din",      din, 0);
      check("reset pl",       pl, 0);
      check("reset busy",     busy, 0);
      check("reset in_ready", in_ready, 1);
      @(negedge clk);
      rstn = 1'b1;

      // flush with an empty batch must be ignored
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("empty flush ignored busy", busy, 0);

      foreach (vecs[v]) begin
         pl_base = pl_cnt;
         for (int i = 0; i < vecs[v].nsamp; i++)
            send(vecs[v].samples[i*5 +: 5], vecs[v].flush_last && i == vecs[v].nsamp - 1);
         @(negedge clk);
         check({vecs[v].name, " din"},      din, vecs[v].exp_din);
         check({vecs[v].name, " busy"},     busy, 1);
         check({vecs[v].name, " in_ready"}, in_ready, 0);
         check({vecs[v].name, " pl"},       pl, 1);
         @(negedge clk);
         check({vecs[v].name, " pl one cycle"}, pl_cnt - pl_base, 1);
         check({vecs[v].name, " din stable"},   din, vecs[v].exp_din);
         release_hold(vecs[v].name);
      end

      // downstream stall: batch waits in LOAD without a strobe
      acc_ready = 1'b0;
      pl_base   = pl_cnt;
      send(5'd1, 1'b0); send(5'd2, 1'b0); send(5'd3, 1'b0); send(5'd4, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall pl", pl, 0);
         check("stall din", din, 20'h00865);
         check("stall in_ready", in_ready, 0);
      end
      acc_ready = 1'b1;
      #1 check("stall release pl", pl, 1);
      @(negedge clk);
      check("stall pl count", pl_cnt - pl_base, 1);
      release_hold("stall");

      // reset mid-batch discards the partial samples
      send(5'h1F, 1'b0); send(5'h1F, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midreset in_ready", in_ready, 1);
      check("midreset busy", busy, 0);
      check("midreset din", din, 0);
      @(negedge clk);
      rstn = 1'b1;
      pl_base = pl_cnt;
      send(5'd8, 1'b0); send(5'd0, 1'b0); send(5'd0, 1'b0); send(5'd0, 1'b0);
      @(negedge clk);
      check("post-reset din", din, 20'h01000);
      @(negedge clk);
      check("post-reset pl count", pl_cnt - pl_base, 1);
      release_hold("postreset");

      // reset while a full batch waits in LOAD: it must never be strobed
      acc_ready = 1'b0;
      send(5'd7, 1'b0); send(5'd7, 1'b0); send(5'd7, 1'b0); send(5'd7, 1'b0);
      @(negedge clk);
      check("load before reset busy", busy, 1);
      pl_base = pl_cnt;
      rstn = 1'b0;
      #1 check("load reset din", din, 0);
      @(negedge clk);
      rstn      = 1'b1;
      acc_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("load reset no pl", pl_cnt - pl_base, 0);
      check("load reset in_ready", in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
